// File: rtl/bram_tx_sequencer_pkg.sv
// Shared state encoding and constants for the BRAM-to-transmitter byte sequencer.
package bram_tx_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  // Default UART clocks per bit (125 MHz / 115200); the transmitter lives outside this block.
  localparam int unsigned CPB     = 1085;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LATCH    = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_RFN = 3'd4,
    ST_GAP      = 3'd5,
    ST_FINISH   = 3'd6
  } state_t;

endpackage

// File: rtl/bram_tx_sequencer_seq_timer.sv
// Clearable up-counter that flags the LIMIT-th enabled clock since the last clear.
module seq_timer
  import bram_tx_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit_c = en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bram_tx_sequencer.sv
// Reads a message byte-by-byte from BRAM and hands each byte to an external
// transmitter using a one-clock enable / ready-pulse handshake.
module bram_tx_sequencer
  import bram_tx_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned GAP     = 0,
  parameter int unsigned TIMEOUT = 16384
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_en,
  input  logic [7:0]        i_rdata,
  output logic [7:0]        o_data,
  output logic              o_nTx_EN,
  input  logic              i_RFN,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_count
);

  localparam int unsigned LEN_W   = ADDR_W + 1;
  localparam int unsigned GAP_LIM = (GAP > 0) ? GAP : 1;
  localparam int unsigned GAP_W   = (GAP_LIM > 1) ? $clog2(GAP_LIM) : 1;
  // The SEND clock counts toward the budget, so WAIT_RFN itself may last TIMEOUT-1 clocks.
  localparam int unsigned TO_LIM  = (TIMEOUT > 2) ? (TIMEOUT - 1) : 1;
  localparam int unsigned TO_W    = (TO_LIM > 1) ? $clog2(TO_LIM) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                abort_q, abort_d, abort_c;
  logic [LEN_W-1:0]    count_d;
  logic [7:0]          data_d;
  logic                err_d;
  logic [ADDR_W-1:0]   o_addr_d;
  logic                en_d, ntx_d, busy_d, done_d;
  logic                gap_hit_c, to_hit_c;
  logic                gap_clr_c, gap_en_c, to_clr_c, to_en_c;

  assign gap_clr_c = (state_q == ST_WAIT_RFN);
  assign gap_en_c  = (state_q == ST_GAP);
  assign to_clr_c  = (state_q == ST_SEND);
  assign to_en_c   = (state_q == ST_WAIT_RFN);

  seq_timer #(
    .CNT_W (GAP_W),
    .LIMIT (GAP_LIM)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (nRST),
    .clr   (gap_clr_c),
    .en    (gap_en_c),
    .hit_c (gap_hit_c)
  );

  seq_timer #(
    .CNT_W (TO_W),
    .LIMIT (TO_LIM)
  ) u_timeout_timer (
    .clk   (clk),
    .rst_n (nRST),
    .clr   (to_clr_c),
    .en    (to_en_c),
    .hit_c (to_hit_c)
  );

  // An abort raised this very clock acts immediately, not one clock after it is latched.
  assign abort_c = abort_q | i_abort;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    count_d = o_count;
    data_d  = o_data;
    err_d   = o_err;
    abort_d = (state_q != ST_IDLE) && abort_c;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d  = i_base;
          len_d   = i_len;
          count_d = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          state_d = (i_len == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: state_d = abort_c ? ST_FINISH : ST_LATCH;
      ST_LATCH: begin
        data_d  = i_rdata;
        state_d = abort_c ? ST_FINISH : ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT_RFN;
      ST_WAIT_RFN: begin
        if (i_RFN) begin
          count_d = o_count + LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          if ((count_d == len_q) || abort_c) begin
            state_d = ST_FINISH;
          end else if (GAP != 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (to_hit_c) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_GAP: begin
        if (abort_c) begin
          state_d = ST_FINISH;
        end else if (gap_hit_c) begin
          state_d = ST_FETCH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    en_d     = (state_d == ST_FETCH);
    o_addr_d = (state_d == ST_FETCH) ? addr_d : o_addr;
    ntx_d    = (state_d != ST_SEND);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_FINISH);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      abort_q  <= 1'b0;
      o_addr   <= '0;
      o_en     <= 1'b0;
      o_data   <= '0;
      o_nTx_EN <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_count  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      abort_q  <= abort_d;
      o_addr   <= o_addr_d;
      o_en     <= en_d;
      o_data   <= data_d;
      o_nTx_EN <= ntx_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_err    <= err_d;
      o_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_bram_tx_sequencer.sv
// Directed bench: two sequencers (GAP=0 and GAP=5, TIMEOUT=64) driven from one
// stimulus stream, each with its own BRAM and transmitter model.
module tb_bram_tx_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        nRST;
  logic        i_start, i_abort;
  logic [9:0]  i_base;
  logic [10:0] i_len;
  logic [1:0]  en, ntx, busy, done, err, rfn;
  logic [9:0]  addr  [2];
  logic [7:0]  rdata [2];
  logic [7:0]  data  [2];
  logic [10:0] count [2];

  logic [7:0]  mem [1024];
  logic [9:0]  exp_base;
  logic        mute;
  int          cyc = 0;
  int          n_chk = 0, n_err = 0;
  int          en_cnt [2], tx_cnt [2], done_cnt [2], rfn_cnt [2], tx_cd [2];
  int          first_tx [2], done_cyc [2], en2_cyc [2], rfn1_cyc [2];
  logic [9:0]  addr_log [$];
  int          t0;

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_tx_sequencer #(.ADDR_W(10), .GAP(0), .TIMEOUT(64)) u_dut0 (
    .clk(clk), .nRST(nRST), .i_start(i_start), .i_base(i_base), .i_len(i_len),
    .i_abort(i_abort), .o_addr(addr[0]), .o_en(en[0]), .i_rdata(rdata[0]),
    .o_data(data[0]), .o_nTx_EN(ntx[0]), .i_RFN(rfn[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_err(err[0]), .o_count(count[0])
  );

  bram_tx_sequencer #(.ADDR_W(10), .GAP(5), .TIMEOUT(64)) u_dut1 (
    .clk(clk), .nRST(nRST), .i_start(i_start), .i_base(i_base), .i_len(i_len),
    .i_abort(i_abort), .o_addr(addr[1]), .o_en(en[1]), .i_rdata(rdata[1]),
    .o_data(data[1]), .o_nTx_EN(ntx[1]), .i_RFN(rfn[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_err(err[1]), .o_count(count[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // BRAM, transmitter and event monitor per DUT, all on the falling edge.
  always @(negedge clk) begin
    logic [9:0] ea;
    for (int d = 0; d < 2; d++) begin
      rfn[d] = 1'b0;
      if (!nRST) begin
        tx_cd[d] = 0;
      end else begin
        if (tx_cd[d] != 0) begin
          tx_cd[d]--;
          if (tx_cd[d] == 0) begin
            rfn[d] = 1'b1;
            rfn_cnt[d]++;
            if (rfn_cnt[d] == 1) rfn1_cyc[d] = cyc;
          end
        end
        if (en[d]) begin
          en_cnt[d]++;
          rdata[d] = mem[addr[d]];
          if (en_cnt[d] == 2) en2_cyc[d] = cyc;
          if (d == 0) addr_log.push_back(addr[d]);
        end
        if (!ntx[d]) begin
          tx_cnt[d]++;
          if (tx_cnt[d] == 1) first_tx[d] = cyc;
          if (d == 0) begin
            ea = exp_base + 10'(tx_cnt[d] - 1);
            chk("tx_data", 32'(data[d]), 32'(mem[ea]));
          end
          if (!mute) tx_cd[d] = LAT;
        end
        if (done[d]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
        end
      end
    end
  end

  task automatic clr_mon();
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0; tx_cnt[d] = 0; done_cnt[d] = 0; rfn_cnt[d] = 0;
      first_tx[d] = -1; done_cyc[d] = -1; en2_cyc[d] = -1; rfn1_cyc[d] = -1;
    end
    addr_log.delete();
  endtask

  task automatic start(input logic [9:0] b, input logic [10:0] l, output int t);
    @(posedge clk);
    #1;
    clr_mon();
    exp_base = b;
    @(negedge clk);
    i_start = 1'b1; i_base = b; i_len = l;
    t = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int d, input int budget, input string tag);
    int n = 0;
    while (done_cnt[d] == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(done_cnt[d] != 0), 32'd1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ntx"},   32'(ntx[0]),   32'd1);
    chk({tag, "_en"},    32'(en[0]),    32'd0);
    chk({tag, "_addr"},  32'(addr[0]),  32'd0);
    chk({tag, "_data"},  32'(data[0]),  32'd0);
    chk({tag, "_busy"},  32'(busy[0]),  32'd0);
    chk({tag, "_done"},  32'(done[0]),  32'd0);
    chk({tag, "_err"},   32'(err[0]),   32'd0);
    chk({tag, "_count"}, 32'(count[0]), 32'd0);
  endtask

  initial begin
    nRST = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_base = '0; i_len = '0;
    mute = 1'b0; exp_base = '0; rfn = '0; rdata[0] = '0; rdata[1] = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    clr_mon();
    repeat (2) @(negedge clk);
    #1;
    chk_rst("rst");
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // Wrapping four-byte message.
    start(10'h3FE, 11'd4, t0);
    at(t0 + 2);
    chk("t1_busy_mid", 32'(busy[0]), 32'd1);
    wait_done(0, 100, "t1_wait0");
    repeat (3) @(negedge clk);
    #1;
    chk("t1_nfetch", 32'(en_cnt[0]), 32'd4);
    chk("t1_addr0", 32'(addr_log[0]), 32'h3FE);
    chk("t1_addr1", 32'(addr_log[1]), 32'h3FF);
    chk("t1_addr2", 32'(addr_log[2]), 32'h000);
    chk("t1_addr3", 32'(addr_log[3]), 32'h001);
    chk("t1_ntx", 32'(tx_cnt[0]), 32'd4);
    chk("t1_first_tx", 32'(first_tx[0] - t0), 32'd3);
    chk("t1_count", 32'(count[0]), 32'd4);
    chk("t1_done_n", 32'(done_cnt[0]), 32'd1);
    chk("t1_done_at", 32'(done_cyc[0] - t0), 32'd22);
    chk("t1_busy_end", 32'(busy[0]), 32'd0);
    wait_done(1, 100, "t1_wait1");
    chk("t1_done_at_gap", 32'(done_cyc[1] - t0), 32'd37);
    chk("t1_count_gap", 32'(count[1]), 32'd4);

    // Zero-length request.
    start(10'h055, 11'd0, t0);
    at(t0 + 1);
    chk("t2_busy", 32'(busy[0]), 32'd1);
    chk("t2_done_early", 32'(done[0]), 32'd0);
    at(t0 + 2);
    chk("t2_done", 32'(done[0]), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("t2_no_en", 32'(en_cnt[0] + en_cnt[1]), 32'd0);
    chk("t2_no_tx", 32'(tx_cnt[0] + tx_cnt[1]), 32'd0);
    chk("t2_done_n", 32'(done_cnt[0]), 32'd1);

    // Inter-byte gap on the GAP=5 instance.
    start(10'h020, 11'd2, t0);
    wait_done(1, 100, "t3_wait1");
    chk("t3_gap", 32'(en2_cyc[1] - rfn1_cyc[1]), 32'd6);
    chk("t3_done_at", 32'(done_cyc[1] - t0), 32'd17);
    chk("t3_count", 32'(count[1]), 32'd2);
    chk("t3_done0", 32'(done_cyc[0] - t0), 32'd12);
    repeat (3) @(negedge clk);

    // Transmitter never answers.
    mute = 1'b1;
    start(10'h010, 11'd3, t0);
    wait_done(0, 200, "t4_wait0");
    chk("t4_err", 32'(err[0]), 32'd1);
    chk("t4_done_at", 32'(done_cyc[0] - first_tx[0]), 32'd65);
    chk("t4_ntx", 32'(tx_cnt[0]), 32'd1);
    chk("t4_count", 32'(count[0]), 32'd0);
    wait_done(1, 200, "t4_wait1");
    repeat (5) @(negedge clk);
    #1;
    chk("t4_sticky", 32'(err[0]), 32'd1);
    mute = 1'b0;

    // Abort while byte 2 is in flight.
    start(10'h100, 11'd8, t0);
    at(t0 + 1);
    chk("t5_err_clr", 32'(err[0]), 32'd0);
    at(t0 + 9);
    i_abort = 1'b1;
    at(t0 + 10);
    i_abort = 1'b0;
    wait_done(0, 100, "t5_wait0");
    wait_done(1, 100, "t5_wait1");
    repeat (20) @(negedge clk);
    #1;
    chk("t5_count", 32'(count[0]), 32'd2);
    chk("t5_ntx", 32'(tx_cnt[0]), 32'd2);
    chk("t5_nfetch", 32'(en_cnt[0]), 32'd2);
    chk("t5_done_n", 32'(done_cnt[0]), 32'd1);
    chk("t5_done_at", 32'(done_cyc[0] - t0), 32'd12);
    chk("t5_gap_count", 32'(count[1]), 32'd1);
    chk("t5_gap_nfetch", 32'(en_cnt[1]), 32'd1);
    chk("t5_gap_done_at", 32'(done_cyc[1] - t0), 32'd11);

    // Reset in the middle of WAIT_RFN, then a fresh transfer.
    mute = 1'b1;
    start(10'h200, 11'd4, t0);
    at(t0 + 5);
    chk("t6_busy_pre", 32'(busy[0]), 32'd1);
    nRST = 1'b0;
    #1;
    chk_rst("t6_rst");
    repeat (2) @(negedge clk);
    #1;
    nRST = 1'b1;
    mute = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t6_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
    start(10'h005, 11'd1, t0);
    wait_done(0, 50, "t6_wait0");
    chk("t6_count", 32'(count[0]), 32'd1);
    chk("t6_addr", 32'(addr_log[0]), 32'h005);
    chk("t6_done_at", 32'(done_cyc[0] - t0), 32'd7);
    wait_done(1, 50, "t6_wait1");
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
